// File: rtl/decode_instr_buffer.sv
// decode_instr_buffer
//
// Fetch-to-decode instruction buffer. This block replaces the old single-entry
// decode instruction register. It holds up to DEPTH instruction/PC pairs in a
// show-ahead FIFO, so the oldest pair is always on the decode outputs. It
// honours decode stall and pipeline flush, and back-pressures fetch with
// fetch_ready.
//
// Parameters:
//   ILEN       instruction width in bits
//   XLEN       PC width in bits
//   DEPTH      number of entries (power of two, >= 2)
//   NOP_INSTR  value driven on decode_instr when nothing is buffered
//
// Ports:
//   clk           clock, all state updates on posedge
//   rst_n         synchronous active-low reset
//   fetch_valid   fetch presents an instruction this cycle
//   fetch_ready   buffer can accept (push = fetch_valid && fetch_ready)
//   fetch_instr   fetched instruction
//   fetch_pc      PC of fetched instruction
//   decode_stall  decode cannot consume this cycle
//   flush         discard every buffered entry (branch/jump redirect)
//   decode_valid  decode_instr/decode_pc hold a real instruction
//   decode_instr  oldest buffered instruction, else NOP_INSTR
//   decode_pc     PC of oldest entry, else 0
//   count         number of occupied entries
//
// Optional feature: define DECODE_INSTR_BUFFER_PERF_EN to add two 32-bit
// counters:
//   perf_stall_cycles  counts cycles where decode stalls on a valid entry
//   perf_empty_cycles  counts cycles where the buffer is empty out of reset

module decode_instr_buffer #(
    parameter int               ILEN      = 32,
    parameter int               XLEN      = 32,
    parameter int               DEPTH     = 2,
    parameter logic [ILEN-1:0]  NOP_INSTR = ILEN'(32'h0000_0013)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [ILEN-1:0]            fetch_instr,
    input  logic [XLEN-1:0]            fetch_pc,
    input  logic                       decode_stall,
    input  logic                       flush,
    output logic                       decode_valid,
    output logic [ILEN-1:0]            decode_instr,
    output logic [XLEN-1:0]            decode_pc,
    output logic [$clog2(DEPTH):0]     count
`ifdef DECODE_INSTR_BUFFER_PERF_EN
    ,
    output logic [31:0]                perf_stall_cycles,
    output logic [31:0]                perf_empty_cycles
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;

    // fetch_ready depends only on the registered count and on reset. No
    // combinational path runs from decode_stall or flush back into fetch.
    // A full buffer refuses a push even when a pop happens in the same cycle.
    assign fetch_ready  = rst_n && (count_q < CW'(DEPTH));

    // Every output is gated with rst_n. While reset is held, decode sees an
    // empty buffer before the synchronous clear has taken effect.
    assign decode_valid = rst_n && (count_q != '0);
    assign count        = rst_n ? count_q : '0;
    assign decode_instr = decode_valid ? instr_mem[rd_ptr] : NOP_INSTR;
    assign decode_pc    = decode_valid ? pc_mem[rd_ptr]    : '0;

    assign push = fetch_valid && fetch_ready;
    assign pop  = decode_valid && !decode_stall && !flush;

    // Pointer and occupancy state. Flush sits just below reset, so a push or
    // pop in a flush cycle is discarded. Pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset. An entry is only observed once count
    // covers it, and count is cleared by reset and by flush.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            instr_mem[wr_ptr] <= fetch_instr;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

`ifdef DECODE_INSTR_BUFFER_PERF_EN
    // Performance counters. These wrap freely and are cleared only by reset.
    // A flush cycle adds nothing to the stall count because no head is
    // being held. Being in the else branch already implies rst_n is high,
    // so the empty count needs no separate rst_n term.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_empty_cycles <= '0;
        end else begin
            if (decode_valid && decode_stall && !flush) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (count_q == '0) begin
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_instr_buffer.sv
// tb_decode_instr_buffer
//
// Self-checking bench for decode_instr_buffer (default parameters, DEPTH=2).
// A table of per-cycle input/expected-output records covers the main flows.
// Hand-written sequences then cover flush with a live push, the outputs while
// reset is held, and (when DECODE_INSTR_BUFFER_PERF_EN is defined) the
// performance counters.

module tb_decode_instr_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        decode_stall;
    logic        flush;
    logic        decode_valid;
    logic [31:0] decode_instr;
    logic [31:0] decode_pc;
    logic [1:0]  count;
`ifdef DECODE_INSTR_BUFFER_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_empty_cycles;
`endif

    int compared;
    int mismatched;

    typedef struct {
        logic        rst_n;
        logic        fv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [1:0]  ec;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    decode_instr_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_instr  (fetch_instr),
        .fetch_pc     (fetch_pc),
        .decode_stall (decode_stall),
        .flush        (flush),
        .decode_valid (decode_valid),
        .decode_instr (decode_instr),
        .decode_pc    (decode_pc),
        .count        (count)
`ifdef DECODE_INSTR_BUFFER_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_empty_cycles (perf_empty_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs.
    task automatic applyStimulus(input logic r, input logic fv, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic st, input logic fl);
        rst_n        = r;
        fetch_valid  = fv;
        fetch_instr  = instr;
        fetch_pc     = pc;
        decode_stall = st;
        flush        = fl;
    endtask

    // Compare every visible output against the expected values.
    task automatic checkOutput(input string tag, input logic ev, input logic [31:0] ei,
                               input logic [31:0] ep, input logic [1:0] ec, input logic er);
        compared++;
        if (decode_valid !== ev) begin
            mismatched++;
            $display("[TB] FAIL %s decode_valid: got %0b, expected %0b", tag, decode_valid, ev);
        end
        compared++;
        if (decode_instr !== ei) begin
            mismatched++;
            $display("[TB] FAIL %s decode_instr: got %h, expected %h", tag, decode_instr, ei);
        end
        compared++;
        if (decode_pc !== ep) begin
            mismatched++;
            $display("[TB] FAIL %s decode_pc: got %h, expected %h", tag, decode_pc, ep);
        end
        compared++;
        if (count !== ec) begin
            mismatched++;
            $display("[TB] FAIL %s count: got %0d, expected %0d", tag, count, ec);
        end
        compared++;
        if (fetch_ready !== er) begin
            mismatched++;
            $display("[TB] FAIL %s fetch_ready: got %0b, expected %0b", tag, fetch_ready, er);
        end
    endtask

    // Apply inputs, clock once, then sample shortly after the edge.
    task automatic stepCycle(input logic r, input logic fv, input logic [31:0] instr,
                             input logic [31:0] pc, input logic st, input logic fl);
        applyStimulus(r, fv, instr, pc, st, fl);
        @(posedge clk);
        #1;
    endtask

`ifdef DECODE_INSTR_BUFFER_PERF_EN
    task automatic checkPerf(input string tag, input logic [31:0] es, input logic [31:0] ee);
        compared++;
        if (perf_stall_cycles !== es) begin
            mismatched++;
            $display("[TB] FAIL %s perf_stall_cycles: got %0d, expected %0d", tag, perf_stall_cycles, es);
        end
        compared++;
        if (perf_empty_cycles !== ee) begin
            mismatched++;
            $display("[TB] FAIL %s perf_empty_cycles: got %0d, expected %0d", tag, perf_empty_cycles, ee);
        end
    endtask
`endif

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Fields: rst_n, fv, instr, pc, stall, flush -> valid, instr, pc, count, ready
        // Single push, then drain.
        vecs.push_back('{1'b0, 1'b0, 32'h0,         32'h0,   1'b0, 1'b0, 1'b0, NOP,           32'h0,   2'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0, 1'b1, 32'h0050_0093, 32'h100, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h0,         32'h0,   1'b0, 1'b0, 1'b0, NOP,           32'h0,   2'd0, 1'b1});
        // Fill under stall, a refused third push, then drain in order.
        vecs.push_back('{1'b1, 1'b1, 32'h0010_0113, 32'h100, 1'b1, 1'b0, 1'b1, 32'h0010_0113, 32'h100, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 32'h0020_0193, 32'h104, 1'b1, 1'b0, 1'b1, 32'h0010_0113, 32'h100, 2'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'h0030_0213, 32'h108, 1'b1, 1'b0, 1'b1, 32'h0010_0113, 32'h100, 2'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'h0030_0213, 32'h108, 1'b0, 1'b0, 1'b1, 32'h0020_0193, 32'h104, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h0,         32'h0,   1'b0, 1'b0, 1'b0, NOP,           32'h0,   2'd0, 1'b1});
        // Streaming: 8 back-to-back pushes, each delivered the cycle after its push.
        for (int k = 0; k < 8; k++) begin
            logic [31:0] p;
            p = 32'(k * 4);
            vecs.push_back('{1'b1, 1'b1, 32'hC000_0000 + p, p, 1'b0, 1'b0, 1'b1, 32'hC000_0000 + p, p, 2'd1, 1'b1});
        end
        vecs.push_back('{1'b1, 1'b0, 32'h0,         32'h0,   1'b0, 1'b0, 1'b0, NOP,           32'h0,   2'd0, 1'b1});
        // Flush while full, with a push presented in the flush cycle.
        vecs.push_back('{1'b1, 1'b1, 32'hA000_0300, 32'h300, 1'b1, 1'b0, 1'b1, 32'hA000_0300, 32'h300, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 32'hA000_0304, 32'h304, 1'b1, 1'b0, 1'b1, 32'hA000_0300, 32'h300, 2'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'hA000_0200, 32'h200, 1'b0, 1'b1, 1'b0, NOP,           32'h0,   2'd0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 32'hA000_0204, 32'h204, 1'b0, 1'b0, 1'b1, 32'hA000_0204, 32'h204, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h0,         32'h0,   1'b0, 1'b0, 1'b0, NOP,           32'h0,   2'd0, 1'b1});
        // Reset mid-operation with one entry held under stall.
        vecs.push_back('{1'b1, 1'b1, 32'hB000_0400, 32'h400, 1'b1, 1'b0, 1'b1, 32'hB000_0400, 32'h400, 2'd1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 1'b0, NOP,           32'h0,   2'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,         32'h0,   1'b0, 1'b0, 1'b0, NOP,           32'h0,   2'd0, 1'b1});

        foreach (vecs[i]) begin
            stepCycle(vecs[i].rst_n, vecs[i].fv, vecs[i].instr, vecs[i].pc, vecs[i].stall, vecs[i].flush);
            checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep, vecs[i].ec, vecs[i].er);
        end

        // Flush while fetch_ready=1: the push presented with flush is dropped.
        stepCycle(1'b1, 1'b1, 32'hD000_0500, 32'h500, 1'b1, 1'b0);
        checkOutput("flushA_push", 1'b1, 32'hD000_0500, 32'h500, 2'd1, 1'b1);
        stepCycle(1'b1, 1'b1, 32'hD000_0504, 32'h504, 1'b0, 1'b1);
        checkOutput("flushA_flush", 1'b0, NOP, 32'h0, 2'd0, 1'b1);
        stepCycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("flushA_after", 1'b0, NOP, 32'h0, 2'd0, 1'b1);

        // Outputs read as empty as soon as rst_n goes low, before the clock edge.
        stepCycle(1'b1, 1'b1, 32'hE000_0600, 32'h600, 1'b1, 1'b0);
        checkOutput("rstB_push", 1'b1, 32'hE000_0600, 32'h600, 2'd1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        checkOutput("rstB_held", 1'b0, NOP, 32'h0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rstB_edge", 1'b0, NOP, 32'h0, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("rstB_release", 1'b0, NOP, 32'h0, 2'd0, 1'b1);

`ifdef DECODE_INSTR_BUFFER_PERF_EN
        begin
            logic [31:0] s0;
            logic [31:0] e0;
            stepCycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            #1;
            checkPerf("perf_reset", 32'd0, 32'd0);
            // The push cycle itself is an empty cycle, so the baseline is taken after it.
            stepCycle(1'b1, 1'b1, 32'hF000_0700, 32'h700, 1'b1, 1'b0);
            s0 = perf_stall_cycles;
            e0 = perf_empty_cycles;
            for (int c = 0; c < 3; c++) stepCycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checkPerf("perf_stall3", s0 + 32'd3, e0);
            stepCycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            for (int c = 0; c < 2; c++) stepCycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            checkPerf("perf_empty2", s0 + 32'd3, e0 + 32'd2);
            // A flush with a held entry under stall leaves both counters alone.
            stepCycle(1'b1, 1'b1, 32'hF000_0704, 32'h704, 1'b1, 1'b0);
            s0 = perf_stall_cycles;
            e0 = perf_empty_cycles;
            stepCycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
            checkPerf("perf_flush", s0, e0);
            checkOutput("perf_flush_out", 1'b0, NOP, 32'h0, 2'd0, 1'b1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/decode_instr_buffer.md
Name: decode_instr_buffer

Overview:
Parametrised fetch-to-decode instruction buffer. It is the successor to the single-entry decode instruction register.
- Holds up to DEPTH fetched instruction/PC pairs in a show-ahead FIFO.
- Presents the oldest pair to decode with a valid flag.
- Honours decode stall and pipeline flush.
- Back-pressures fetch with a ready signal.
- Sits between the fetch unit and the decode datapath.

Parameters:
ILEN, 32, instruction width in bits
XLEN, 32, PC width in bits
DEPTH, 2, number of buffer entries; power of two, >= 2
NOP_INSTR, 32'h0000_0013, value driven on decode_instr when no valid entry (ADDI x0,x0,0)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  synchronous active-low reset
fetch_valid  input  1  fetch presents an instruction this cycle
fetch_ready  output  1  buffer can accept; push = fetch_valid && fetch_ready
fetch_instr  input  ILEN  fetched instruction
fetch_pc  input  XLEN  PC of fetched instruction
decode_stall  input  1  decode cannot consume this cycle
flush  input  1  discard all buffered entries (branch/jump redirect)
decode_valid  output  1  decode_instr/decode_pc hold a real instruction
decode_instr  output  ILEN  oldest buffered instruction, else NOP_INSTR
decode_pc  output  XLEN  PC of oldest entry, else 0
count  output  $clog2(DEPTH)+1  current number of occupied entries

Behaviour:
Reset
- rst_n sampled low at posedge: read/write pointers and count go to 0.
- While rst_n is low, outputs are: decode_valid=0, decode_instr=NOP_INSTR, decode_pc=0, count=0, fetch_ready=0.
- Reset mid-operation drops all entries with no partial pop.

Handshakes
- fetch_ready = rst_n && (count < DEPTH). It is a function of registered count only; there is no combinational path from decode_stall or flush.
- pop = decode_valid && !decode_stall && !flush.
- decode_valid = (count != 0). decode_instr/decode_pc come from the entry at the read pointer, with NOP_INSTR/0 substituted when count==0.

Latency
- A push at posedge N is visible on decode outputs after posedge N (one-cycle latency) if the buffer was empty.
- There is no same-cycle bypass.

Full / empty
- Full: fetch_ready=0, so no push occurs even if a pop happens the same cycle. Full throughput therefore needs DEPTH>=2.
- Empty: pop is impossible because decode_valid=0. decode_stall has no effect.

Simultaneous push and pop (not full, not empty)
- Both pointers advance and count is unchanged.

Pointers
- Width $clog2(DEPTH); they wrap naturally modulo DEPTH.
- count is updated as +1 on push only, -1 on pop only, unchanged otherwise.

Flush
- Takes priority over stall, push and pop.
- Next cycle: count=0, both pointers 0, decode_valid=0.
- A push presented in the flush cycle is discarded.
- A push in the cycle after flush is accepted normally.

Stall
- With decode_stall=1, the head entry and decode outputs hold stable.
- Pushes continue until full.

Priority at a posedge: reset > flush > push/pop.

Optional Feature:
Macro DECODE_INSTR_BUFFER_PERF_EN.
- When defined, adds two outputs:
  - perf_stall_cycles (32-bit): increments each cycle with decode_valid && decode_stall && !flush.
  - perf_empty_cycles (32-bit): increments each cycle with count==0 and rst_n high.
- Both counters reset to 0 on rst_n low, and wrap from 32'hFFFF_FFFF to 0.
- Both are unaffected by flush.
- When the macro is undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then push instr 32'h0050_0093 @ pc 32'h100, decode_stall=0 -> next cycle decode_valid=1, decode_instr=32'h0050_0093, decode_pc=32'h100. One cycle later decode_valid=0, decode_instr=32'h13, count=0.
2. DEPTH=2, decode_stall=1, push pc 0x100 and 0x104 back-to-back -> count=2, fetch_ready=0, a third push is refused. Release stall -> outputs 0x100 then 0x104 in order; fetch_ready returns to 1 the cycle after the first pop.
3. Continuous fetch_valid=1 with decode_stall=0 for 8 PCs 0x0..0x1C -> decode receives all 8 in order, one per cycle after the first. count stays <=1 and pointers wrap past DEPTH with no loss.
4. Buffer holds 2 entries, assert flush together with fetch_valid (pc 0x200) -> next cycle count=0, decode_valid=0. pc 0x200 is not delivered; the next push (0x204) is delivered at the following cycle.
5. Buffer holds 1 entry, stall=1, drive rst_n=0 for one cycle -> after the edge decode_valid=0, decode_instr=NOP_INSTR, decode_pc=0, count=0, fetch_ready=0. fetch_ready=1 on the first cycle with rst_n high.
6. With DECODE_INSTR_BUFFER_PERF_EN: 3 stalled cycles holding a valid entry, then 2 empty cycles -> perf_stall_cycles=3, perf_empty_cycles=2. A flush leaves both counter values unchanged.
